// File: rtl/issue_scoreboard_pkg.sv
// Shared definitions for the issue scoreboard: FSM state encoding, the
// opcodes that classify long-latency and serializing instructions, and the
// default limit on in-flight long-latency operations.
package issue_scoreboard_pkg;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } sb_state_e;

    localparam int MAX_OUTSTANDING_DEFAULT = 4;
    localparam int REG_COUNT               = 32;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // Loads and M-extension ops write their destination late.
    function automatic logic is_long_latency_op(input logic [6:0] opcode,
                                                input logic [6:0] funct7);
        return (opcode == OPC_LOAD) ||
               ((opcode == OPC_OP) && (funct7 == FUNCT7_MULDIV));
    endfunction

    // CSR accesses and fences must see an empty pipeline.
    function automatic logic is_serializing_op(input logic [6:0] opcode);
        return (opcode == OPC_SYSTEM) || (opcode == OPC_MISC_MEM);
    endfunction

endpackage

// File: rtl/issue_scoreboard_hazard_check.sv
// Combinational RAW/WAW check of the incoming instruction against the
// pending-write vector. A writeback landing this cycle releases its register
// immediately so the consumer can issue in the same cycle.
module sb_hazard_check
    import issue_scoreboard_pkg::*;
(
    input  logic [REG_COUNT-1:0] pend,
    input  logic [4:0]           rs1_addr,
    input  logic                 rs1_en,
    input  logic [4:0]           rs2_addr,
    input  logic                 rs2_en,
    input  logic [4:0]           rd_addr,
    input  logic                 long_lat,
    input  logic                 wb_valid,
    input  logic [4:0]           wb_rd_addr,
    output logic                 hazard
);

    logic rs1_hit_s;
    logic rs2_hit_s;
    logic rd_hit_s;

    // A source or destination conflicts when its register is pending and not
    // being written back right now; x0 never conflicts.
    always_comb begin
        rs1_hit_s = rs1_en && (rs1_addr != 5'd0) && pend[rs1_addr] &&
                    !(wb_valid && (wb_rd_addr == rs1_addr));
        rs2_hit_s = rs2_en && (rs2_addr != 5'd0) && pend[rs2_addr] &&
                    !(wb_valid && (wb_rd_addr == rs2_addr));
        rd_hit_s  = long_lat && (rd_addr != 5'd0) && pend[rd_addr] &&
                    !(wb_valid && (wb_rd_addr == rd_addr));
        hazard    = rs1_hit_s || rs2_hit_s || rd_hit_s;
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue scoreboard for decode way0: holds back instructions that read or
// overwrite a register still owned by an in-flight long-latency op, bounds
// the number of such ops, and drains the pipeline ahead of serializing ops.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [4:0]  rs1Addr_i,
    input  logic [4:0]  rs2Addr_i,
    input  logic        rs1ReadEnable_i,
    input  logic        rs2ReadEnable_i,
    input  logic [4:0]  rdAddr_i,
    input  logic        longLat_i,
    input  logic        serialize_i,
    input  logic        ready_i,
    input  logic        wbValid_i,
    input  logic [4:0]  wbRdAddr_i,
    input  logic        flush_i,
    output logic        valid_o,
    output logic        ready_o,
    output logic        busy_o,
    output logic        err_o,
    output logic [31:0] stallCnt_o
);

    localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

    sb_state_e            state_r;
    sb_state_e            state_nxt_s;
    logic [REG_COUNT-1:0] pend_r;
    logic [REG_COUNT-1:0] pend_nxt_s;
    logic [REG_COUNT-1:0] wb_mask_s;
    logic [REG_COUNT-1:0] set_mask_s;
    logic [2:0]           count_r;
    logic [2:0]           count_nxt_s;
    logic                 err_r;
    logic [31:0]          stall_r;

    logic hazard_s;
    logic full_s;
    logic serial_s;
    logic block_s;
    logic fire_s;
    logic long_fire_s;

    sb_hazard_check u_hazard (
        .pend       (pend_r),
        .rs1_addr   (rs1Addr_i),
        .rs1_en     (rs1ReadEnable_i),
        .rs2_addr   (rs2Addr_i),
        .rs2_en     (rs2ReadEnable_i),
        .rd_addr    (rdAddr_i),
        .long_lat   (longLat_i),
        .wb_valid   (wbValid_i),
        .wb_rd_addr (wbRdAddr_i),
        .hazard     (hazard_s)
    );

    // Issue gating; a writeback in the same cycle frees a slot for a new long op.
    always_comb begin
        full_s      = longLat_i && (count_r == MAX_CNT) && !wbValid_i;
        serial_s    = serialize_i && valid_i && (count_r != 3'd0);
        block_s     = hazard_s || full_s || serial_s ||
                      (state_r == ST_DRAIN) || flush_i;
        valid_o     = valid_i && !block_s;
        ready_o     = ready_i && !block_s;
        fire_s      = valid_i && ready_o;
        long_fire_s = fire_s && longLat_i;
        busy_o      = (count_r != 3'd0);
        err_o       = err_r;
        stallCnt_o  = stall_r;
    end

    // Drain FSM: enter on a blocked serializing op, leave once nothing is in flight.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (flush_i) begin
                    state_nxt_s = ST_RUN;
                end else if (serial_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (flush_i) begin
                    state_nxt_s = ST_RUN;
                end else if (count_r == 3'd0) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // Pending-write vector update: a new long op's set beats a same-cycle clear.
    always_comb begin
        wb_mask_s  = {REG_COUNT{1'b0}};
        set_mask_s = {REG_COUNT{1'b0}};
        if (wbValid_i) begin
            wb_mask_s = 32'd1 << wbRdAddr_i;
        end else begin
            wb_mask_s = {REG_COUNT{1'b0}};
        end
        if (long_fire_s && (rdAddr_i != 5'd0)) begin
            set_mask_s = 32'd1 << rdAddr_i;
        end else begin
            set_mask_s = {REG_COUNT{1'b0}};
        end
        if (flush_i) begin
            pend_nxt_s = {REG_COUNT{1'b0}};
        end else begin
            pend_nxt_s = (pend_r & ~wb_mask_s) | set_mask_s;
        end
        pend_nxt_s[0] = 1'b0;
    end

    // Outstanding-op counter; a writeback with nothing outstanding is ignored.
    always_comb begin
        count_nxt_s = count_r;
        if (flush_i) begin
            count_nxt_s = 3'd0;
        end else begin
            case ({long_fire_s, wbValid_i})
                2'b10:   count_nxt_s = count_r + 3'd1;
                2'b01:   count_nxt_s = (count_r == 3'd0) ? 3'd0 : (count_r - 3'd1);
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Tracking state: FSM, pending vector, counter, sticky error, stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_RUN;
            pend_r  <= {REG_COUNT{1'b0}};
            count_r <= 3'd0;
            err_r   <= 1'b0;
            stall_r <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            pend_r  <= pend_nxt_s;
            count_r <= count_nxt_s;
            if (wbValid_i && (count_r == 3'd0)) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
            if (valid_i && !ready_o && !flush_i && (stall_r != 32'hFFFF_FFFF)) begin
                stall_r <= stall_r + 32'd1;
            end else begin
                stall_r <= stall_r;
            end
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard. The stimulus process applies one
// vector per cycle and queues the hand-computed outputs expected in that
// cycle; a monitor pops and compares on each falling edge.
module tb_issue_scoreboard;
    import issue_scoreboard_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [4:0]  rs1Addr_i, rs2Addr_i, rdAddr_i, wbRdAddr_i;
    logic        rs1ReadEnable_i, rs2ReadEnable_i;
    logic        longLat_i, serialize_i, ready_i, wbValid_i, flush_i;
    logic        valid_o, ready_o, busy_o, err_o;
    logic [31:0] stallCnt_o;

    issue_scoreboard #(.MAX_OUTSTANDING(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .valid_i         (valid_i),
        .rs1Addr_i       (rs1Addr_i),
        .rs2Addr_i       (rs2Addr_i),
        .rs1ReadEnable_i (rs1ReadEnable_i),
        .rs2ReadEnable_i (rs2ReadEnable_i),
        .rdAddr_i        (rdAddr_i),
        .longLat_i       (longLat_i),
        .serialize_i     (serialize_i),
        .ready_i         (ready_i),
        .wbValid_i       (wbValid_i),
        .wbRdAddr_i      (wbRdAddr_i),
        .flush_i         (flush_i),
        .valid_o         (valid_o),
        .ready_o         (ready_o),
        .busy_o          (busy_o),
        .err_o           (err_o),
        .stallCnt_o      (stallCnt_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       ll;
        logic       ser;
        logic       rdy;
        logic       wbv;
        logic [4:0] wbrd;
        logic       flush;
    } stim_t;

    typedef struct {
        int   id;
        logic v;
        logic r;
        logic b;
        logic e;
        int   stall;   // -1: not checked this cycle
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;
    int   cyc_id = 0;

    function automatic stim_t mk(input logic valid, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic ll, input logic ser,
                                 input logic wbv, input logic [4:0] wbrd,
                                 input logic flush);
        stim_t s;
        s.rst = 1'b0; s.valid = valid; s.rs1 = rs1; s.rs2 = rs2; s.rd = rd;
        s.ll = ll; s.ser = ser; s.rdy = 1'b1; s.wbv = wbv; s.wbrd = wbrd;
        s.flush = flush;
        return s;
    endfunction

    function automatic stim_t idle();
        return mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    endfunction
    function automatic stim_t ld(input logic [4:0] rd);
        return mk(1'b1, 5'd0, 5'd0, rd, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    endfunction
    function automatic stim_t alu(input logic [4:0] rs1, input logic [4:0] rs2);
        return mk(1'b1, rs1, rs2, 5'd7, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    endfunction
    function automatic stim_t csr();
        return mk(1'b1, 5'd0, 5'd0, 5'd10, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    endfunction
    function automatic stim_t with_wb(input stim_t s, input logic [4:0] rd);
        stim_t t;
        t = s; t.wbv = 1'b1; t.wbrd = rd;
        return t;
    endfunction

    // Apply one vector for a cycle and queue what the DUT must show in it.
    task automatic cyc(input stim_t s, input logic ev, input logic er,
                       input logic eb, input logic ee, input int es);
        exp_t e;
        @(posedge clk);
        #1;
        rst             = s.rst;
        valid_i         = s.valid;
        rs1Addr_i       = s.rs1;
        rs2Addr_i       = s.rs2;
        rs1ReadEnable_i = s.valid;
        rs2ReadEnable_i = s.valid;
        rdAddr_i        = s.rd;
        longLat_i       = s.ll;
        serialize_i     = s.ser;
        ready_i         = s.rdy;
        wbValid_i       = s.wbv;
        wbRdAddr_i      = s.wbrd;
        flush_i         = s.flush;
        cyc_id++;
        e.id = cyc_id; e.v = ev; e.r = er; e.b = eb; e.e = ee; e.stall = es;
        exp_q.push_back(e);
    endtask

    task automatic chk(input int id, input string name, input longint got, input longint want);
        total++;
        if (got == want) passed++;
        else $display("FAIL c%0d %s got %0d want %0d", id, name, got, want);
    endtask

    // Monitor: compare queued expectations against the DUT mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.id, "valid_o", longint'(valid_o), longint'(e.v));
            chk(e.id, "ready_o", longint'(ready_o), longint'(e.r));
            chk(e.id, "busy_o",  longint'(busy_o),  longint'(e.b));
            chk(e.id, "err_o",   longint'(err_o),   longint'(e.e));
            if (e.stall >= 0) chk(e.id, "stallCnt_o", longint'(stallCnt_o), longint'(e.stall));
        end
    end

    initial begin
        stim_t s;
        rst = 1'b1; valid_i = 1'b0; rs1Addr_i = 5'd0; rs2Addr_i = 5'd0;
        rs1ReadEnable_i = 1'b0; rs2ReadEnable_i = 1'b0; rdAddr_i = 5'd0;
        longLat_i = 1'b0; serialize_i = 1'b0; ready_i = 1'b1;
        wbValid_i = 1'b0; wbRdAddr_i = 5'd0; flush_i = 1'b0;
        repeat (2) @(posedge clk);

        // reset state
        cyc(idle(), 1'b0, 1'b1, 1'b0, 1'b0, 0);
        // load x5 then RAW consumer held until writeback
        cyc(ld(5'd5), 1'b1, 1'b1, 1'b0, 1'b0, 0);
        cyc(alu(5'd5, 5'd0), 1'b0, 1'b0, 1'b1, 1'b0, 0);
        cyc(alu(5'd5, 5'd0), 1'b0, 1'b0, 1'b1, 1'b0, 1);
        cyc(with_wb(alu(5'd5, 5'd0), 5'd5), 1'b1, 1'b1, 1'b1, 1'b0, 2);
        cyc(idle(), 1'b0, 1'b1, 1'b0, 1'b0, 2);
        // fill to four loads, fifth blocked, released by same-cycle writeback
        for (int i = 1; i <= 4; i++)
            cyc(ld(5'(i)), 1'b1, 1'b1, (i != 1), 1'b0, 2);
        cyc(ld(5'd6), 1'b0, 1'b0, 1'b1, 1'b0, 2);
        cyc(with_wb(ld(5'd6), 5'd1), 1'b1, 1'b1, 1'b1, 1'b0, 3);
        cyc(ld(5'd7), 1'b0, 1'b0, 1'b1, 1'b0, 3);      // still four in flight
        cyc(with_wb(idle(), 5'd2), 1'b0, 1'b1, 1'b1, 1'b0, 4);
        cyc(with_wb(idle(), 5'd3), 1'b0, 1'b1, 1'b1, 1'b0, 4);
        cyc(with_wb(idle(), 5'd4), 1'b0, 1'b1, 1'b1, 1'b0, 4);
        cyc(with_wb(idle(), 5'd6), 1'b0, 1'b1, 1'b1, 1'b0, 4);
        cyc(idle(), 1'b0, 1'b1, 1'b0, 1'b0, 4);
        // serializing op with two outstanding: drain, then issue
        cyc(ld(5'd8), 1'b1, 1'b1, 1'b0, 1'b0, 4);
        cyc(ld(5'd9), 1'b1, 1'b1, 1'b1, 1'b0, 4);
        cyc(csr(), 1'b0, 1'b0, 1'b1, 1'b0, 4);
        cyc(with_wb(csr(), 5'd8), 1'b0, 1'b0, 1'b1, 1'b0, 5);
        cyc(with_wb(csr(), 5'd9), 1'b0, 1'b0, 1'b1, 1'b0, 6);
        cyc(csr(), 1'b0, 1'b0, 1'b0, 1'b0, 7);          // count 0, still draining
        cyc(csr(), 1'b1, 1'b1, 1'b0, 1'b0, 8);
        // flush discards three pending loads
        cyc(ld(5'd1), 1'b1, 1'b1, 1'b0, 1'b0, 8);
        cyc(ld(5'd2), 1'b1, 1'b1, 1'b1, 1'b0, 8);
        cyc(ld(5'd3), 1'b1, 1'b1, 1'b1, 1'b0, 8);
        s = alu(5'd1, 5'd0); s.flush = 1'b1;
        cyc(s, 1'b0, 1'b0, 1'b1, 1'b0, 8);
        cyc(alu(5'd1, 5'd0), 1'b1, 1'b1, 1'b0, 1'b0, 8);
        // long op to x0 counts but marks nothing; x0 reader never stalls
        cyc(ld(5'd0), 1'b1, 1'b1, 1'b0, 1'b0, 8);
        cyc(alu(5'd0, 5'd0), 1'b1, 1'b1, 1'b1, 1'b0, 8);
        cyc(with_wb(idle(), 5'd0), 1'b0, 1'b1, 1'b1, 1'b0, 8);
        cyc(idle(), 1'b0, 1'b1, 1'b0, 1'b0, 8);
        // writeback underflow sets sticky error
        cyc(with_wb(idle(), 5'd3), 1'b0, 1'b1, 1'b0, 1'b0, 8);
        cyc(idle(), 1'b0, 1'b1, 1'b0, 1'b1, 8);
        cyc(idle(), 1'b0, 1'b1, 1'b0, 1'b1, 8);
        // reset in the middle of a drain
        cyc(ld(5'd1), 1'b1, 1'b1, 1'b0, 1'b1, 8);
        cyc(csr(), 1'b0, 1'b0, 1'b1, 1'b1, 8);
        cyc(csr(), 1'b0, 1'b0, 1'b1, 1'b1, 9);
        s = csr(); s.rst = 1'b1;
        cyc(s, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        cyc(csr(), 1'b1, 1'b1, 1'b0, 1'b0, 0);
        // downstream not ready counts as a stall
        s = alu(5'd0, 5'd0); s.rdy = 1'b0;
        cyc(s, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        cyc(idle(), 1'b0, 1'b1, 1'b0, 1'b0, 1);
        // WAW block and same-cycle set/clear of one register
        cyc(ld(5'd5), 1'b1, 1'b1, 1'b0, 1'b0, 1);
        cyc(ld(5'd5), 1'b0, 1'b0, 1'b1, 1'b0, 1);
        cyc(with_wb(ld(5'd5), 5'd5), 1'b1, 1'b1, 1'b1, 1'b0, 2);
        cyc(alu(5'd5, 5'd0), 1'b0, 1'b0, 1'b1, 1'b0, 2);
        cyc(with_wb(idle(), 5'd5), 1'b0, 1'b1, 1'b1, 1'b0, 3);
        cyc(idle(), 1'b0, 1'b1, 1'b0, 1'b0, 3);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            total++;
            $display("FAIL drain expectations left %0d want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/issue_scoreboard.md
ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, meaning max in-flight long-latency ops (load, M-ext), range 1..7.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 valid_i  in  1  decoded way0 instruction valid.
REQ-005 rs1Addr_i / rs2Addr_i  in  5 each  source register addresses.
REQ-006 rs1ReadEnable_i / rs2ReadEnable_i  in  1 each  source used.
REQ-007 rdAddr_i  in  5  destination address; longLat_i  in  1  op writes rd late (load/mul/div).
REQ-008 serialize_i  in  1  op must issue with nothing outstanding (CSR, fence).
REQ-009 ready_i  in  1  DU register can accept.
REQ-010 wbValid_i  in  1  long-latency writeback this cycle; wbRdAddr_i  in  5  its rd.
REQ-011 flush_i  in  1  pipeline flush.
REQ-012 valid_o  out  1  to DU register; ready_o  out  1  to decoder/IFU.
REQ-013 busy_o  out  1  any outstanding op; err_o  out  1  sticky underflow error; stallCnt_o  out  32  stall-cycle counter.

Function
REQ-014 Pass-through, zero latency: fire = valid_i & ready_o; valid_o = valid_i & ~block; ready_o = ready_i & ~block.
REQ-015 block = hazard | full | serial | (state==DRAIN) | flush_i.
REQ-016 hazard: (rs1ReadEnable_i & rs1Addr_i!=0 & pend[rs1Addr_i]) or same for rs2, or (longLat_i & rdAddr_i!=0 & pend[rdAddr_i]) (WAW).
REQ-017 A writeback in the same cycle (wbValid_i & wbRdAddr_i==addr) SHALL clear that address's hazard combinationally.
REQ-018 full = longLat_i & (count==MAX_OUTSTANDING) & ~wbValid_i.
REQ-019 serial = serialize_i & valid_i & (count!=0); on this condition FSM RUN->DRAIN.
REQ-020 FSM states RUN, DRAIN; DRAIN->RUN on the cycle after count reaches 0; flush_i forces RUN.
REQ-021 pend[r] set on fire & longLat_i & rdAddr_i==r, r!=0; cleared on wbValid_i & wbRdAddr_i==r; same-cycle set and clear of r: set wins; pend[0] constant 0.
REQ-022 count: +1 on long fire, -1 on wbValid_i, unchanged if both; 3-bit.
REQ-023 wbValid_i with count==0: count stays 0, err_o set and held until rst.
REQ-024 flush_i: pend all cleared, count=0, state=RUN next edge; valid_o=0 that cycle; later writebacks of flushed ops are not presented (upstream guarantee); err_o unaffected.
REQ-025 stallCnt_o increments when valid_i & ~ready_o & ~flush_i; saturates at 0xFFFFFFFF.
REQ-026 busy_o = (count!=0).

Reset
REQ-027 On rst: pend=0, count=0, state=RUN, err_o=0, stallCnt_o=0; valid_o/ready_o follow REQ-014 from reset state.
REQ-028 rst asserted mid-operation SHALL discard all outstanding tracking immediately.

Structure
REQ-029 Shared package SHALL hold the FSM state enum, opcode constants for load/M-ext/SYSTEM, and MAX_OUTSTANDING default.
REQ-030 One sub-module, sb_hazard_check: combinational rs1/rs2/rd vs pend+writeback compare; remainder in issue_scoreboard.

Verification
REQ-031 Load rd=x5 fires; next cycle add rs1=x5 valid -> valid_o=0, ready_o=0 until wbValid_i with wbRdAddr_i=5, same cycle valid_o=1.
REQ-032 Four loads rd=x1..x4 with MAX=4, fifth load rd=x6 -> blocked; wbValid_i rd=1 same cycle -> fifth fires, count stays 4.
REQ-033 CSR op serialize_i with count=2 -> DRAIN, ready_o=0; two writebacks -> RUN one cycle after count=0, CSR fires.
REQ-034 Three pending loads, flush_i pulse -> next cycle count=0, busy_o=0, add rs1=x1 fires immediately.
REQ-035 wbValid_i at count=0 -> err_o=1 sticky, count=0; rst mid-drain -> state RUN, err_o=0, stallCnt_o=0.
REQ-036 Op with rd=x0 longLat_i=1 -> count increments, pend unchanged; rs1=x0 consumer never stalls.
